// File: rtl/rx_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_stream_arbiter: burst-limited round-robin merge of four FWFT receiver  |
// | streams into one tagged 32-bit word stream with a registered output.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rx_stream_arbiter #(
    parameter int N_CH      = 4,
    parameter int IN_WIDTH  = 30,
    parameter int MAX_BURST = 4
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RSTB,
    input  logic [N_CH-1:0]          CH_EN,
    input  logic [N_CH-1:0]          CH_EMPTY,
    input  logic [N_CH*IN_WIDTH-1:0] CH_DATA,
    output logic [N_CH-1:0]          CH_READ,
    input  logic                     ARB_READY_OUT,
    output logic                     ARB_WRITE_OUT,
    output logic [31:0]              ARB_DATA_OUT
);

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  ptr_q;
    logic [7:0]  cnt_q;
    logic        valid_q;
    logic [31:0] data_q;

    logic [N_CH-1:0]     w_elig;
    logic                w_load_opp;
    logic                w_stay;
    logic [1:0]          w_scan_base;
    logic [1:0]          w_scan_sel;
    logic                w_found;
    logic [1:0]          w_sel;
    logic                w_load;
    logic [IN_WIDTH-1:0] w_sel_data;

    assign w_elig     = CH_EN & ~CH_EMPTY;
    assign w_load_opp = !valid_q || ARB_READY_OUT;

    assign w_stay = (state_q == ST_LOCKED) && w_elig[grant_q] && (cnt_q < C_MAX_BURST);

    // Leaving a lock restarts the scan just past the granted channel in the same cycle.
    assign w_scan_base = (state_q == ST_LOCKED) ? (grant_q + 2'd1) : ptr_q;

    always_comb begin
        logic [1:0] idx;
        idx        = w_scan_base;
        w_found    = 1'b0;
        w_scan_sel = w_scan_base;
        for (int k = 0; k < N_CH; k++) begin
            idx = w_scan_base + 2'(k);
            if (!w_found && w_elig[idx]) begin
                w_found    = 1'b1;
                w_scan_sel = idx;
            end
        end
    end

    assign w_sel      = w_stay ? grant_q : w_scan_sel;
    assign w_load     = BUS_RSTB && w_load_opp && (w_stay || w_found);
    assign w_sel_data = CH_DATA[w_sel*IN_WIDTH +: IN_WIDTH];

    always_comb begin
        CH_READ = '0;
        for (int i = 0; i < N_CH; i++) begin
            CH_READ[i] = w_load && (w_sel == 2'(i));
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RSTB) begin
        if (!BUS_RSTB) begin
            state_q <= ST_IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            if (w_load_opp) begin
                if (w_stay) begin
                    cnt_q <= cnt_q + 8'd1;
                end else if (w_found) begin
                    state_q <= ST_LOCKED;
                    grant_q <= w_scan_sel;
                    cnt_q   <= 8'd1;
                    ptr_q   <= w_scan_base;
                end else begin
                    state_q <= ST_IDLE;
                    ptr_q   <= w_scan_base;
                end
            end
            // A consume without a reload drops valid but keeps the last data word.
            if (w_load) begin
                valid_q <= 1'b1;
                data_q  <= {w_sel, w_sel_data};
            end else if (ARB_READY_OUT) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ARB_WRITE_OUT = valid_q;
    assign ARB_DATA_OUT  = data_q;

endmodule
`default_nettype wire
